regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Register file and scoreboard on the responder side of the integer-pipeline register interface.
- Serves two combinational operand reads (aSel/bSel -> ADAT/BDAT) with same-cycle write bypass.
- Accepts one writeback per cycle (cSel/cOut/cWrite) and holds the 8-bit flags register.
- Counts in-flight writes per register at issue time and raises HAZARD so the issue stage can hold PAUSE.

Parameters:
- DW, 16, data width of each register
- NREG, 8, number of registers
- AW, 3, register select width (log2 NREG)
- FW, 8, flags register width
- CW, 2, per-register pending-write counter width (saturates at 2^CW-1)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- aSel  in  AW  read port A select
- bSel  in  AW  read port B select
- ADAT  out  DW  read data A (combinational)
- BDAT  out  DW  read data B (combinational)
- cSel  in  AW  write select
- cOut  in  DW  write data
- cWrite  in  1  write enable (already PAUSE-gated by the pipeline)
- FLGS_IN  in  FW  flags from ALU
- FLGS_WE  in  1  flags load enable
- FLGS  out  FW  registered flags
- ISSUE  in  1  an op enters the pipeline this cycle
- ISEL  in  AW  destination register of the issuing op
- HAZARD  out  1  aSel or bSel has a nonzero pending count
- PEND  out  NREG  bit i = (count[i] != 0)
- ERR  out  1  sticky scoreboard overflow

Behaviour:
- Reset: when RST=1 at a rising edge:
  - All NREG registers <= 0, FLGS <= 0, all counts <= 0, ERR <= 0.
  - Every other input is ignored that cycle, including cWrite, ISSUE and FLGS_WE.
  - After reset: ADAT = BDAT = 0, HAZARD = 0, PEND = 0.
  - RST asserted mid-operation discards all pending counts; there is no partial state.
- Write: if cWrite=1 and RST=0, reg[cSel] <= cOut at the edge. All registers, including r0, are writable.
- Read latency 0, with bypass:
  - ADAT = (cWrite && cSel==aSel) ? cOut : reg[aSel]. BDAT is formed the same way from bSel.
  - When aSel==bSel, both ports return identical data.
- Flags: FLGS <= FLGS_IN when FLGS_WE=1; otherwise FLGS holds.
- Scoreboard, per register i, with inc = ISSUE && ISEL==i and dec = cWrite && cSel==i:
  - inc only: if count < max, count+1; if count == max, count stays at max and ERR <= 1.
  - dec only: if count > 0, count-1; if count == 0, count stays 0 (an untracked write is legal, no error).
  - inc and dec together: count unchanged, and this never sets ERR.
- HAZARD:
  - HAZARD = (count[aSel] != 0) || (count[bSel] != 0), using registered counts only.
  - The issue stage holds ISSUE=0 while HAZARD=1.
  - Because of the bypass, HAZARD drops the cycle after the final writeback, while the final write itself is forwarded the same cycle.
- ERR is sticky and is cleared only by RST.
- No FSM beyond the counters. Each counter is a saturating up/down counter with the rules above.
- Width rules: selects index modulo NREG, so AW must equal log2(NREG). No sign extension anywhere.

Decomposition:
- Shared package (intpipe_pkg): DW, AW, NREG, FW constants and the reg_sel_t / word_t typedefs, reused by intpipe and the ALU.
- Sub-module sb_counter: one CW-bit saturating up/down counter with inc, dec and overflow outputs. Instantiate NREG times.

Test Plan:
- Reset: hold RST 1 cycle with cWrite=1, cSel=3, cOut=16'hBEEF -> reg3 reads 0, FLGS=0, PEND=0, ERR=0.
- Write/read: write r5=16'h1234, next cycle aSel=5, bSel=5 -> ADAT=BDAT=16'h1234.
- Bypass:
  - Setup: r2=16'h0001.
  - Same cycle: cWrite=1, cSel=2, cOut=16'hA5A5, aSel=2.
  - Expect ADAT=16'hA5A5 that cycle and reg2=16'hA5A5 afterwards.
- Hazard:
  - Stimulus: ISSUE, ISEL=4, then aSel=4.
  - Expect HAZARD=1 and PEND=8'h10.
  - After cWrite, cSel=4: the next cycle HAZARD=0 and PEND=0.
- Simultaneous/overflow:
  - Issue to r1 three times -> count=3.
  - ISSUE+cWrite on r1 in the same cycle -> count stays 3, ERR=0.
  - A fourth lone issue -> count 3, ERR=1, and ERR stays 1 until RST.
- Reset mid-operation: with counts r1=2, r6=1 and FLGS=8'h81, assert RST -> all counts 0, HAZARD=0, FLGS=0, ERR=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer-pipeline register file.
package regfile_sb_pkg;
    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int FW   = 8;
    localparam int CW   = 2;

    typedef logic [AW-1:0] reg_sel_t;
    typedef logic [DW-1:0] word_t;
    typedef logic [FW-1:0] flags_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Register-interface bundle between the issue/writeback pipeline (master)
// and the register file / scoreboard (slave).
interface regfile_sb_if;
    import regfile_sb_pkg::*;

    reg_sel_t          aSel;
    reg_sel_t          bSel;
    word_t             ADAT;
    word_t             BDAT;
    reg_sel_t          cSel;
    word_t             cOut;
    logic              cWrite;
    flags_t            FLGS_IN;
    logic              FLGS_WE;
    flags_t            FLGS;
    logic              ISSUE;
    reg_sel_t          ISEL;
    logic              HAZARD;
    logic [NREG-1:0]   PEND;
    logic              ERR;

    modport master (
        output aSel, bSel, cSel, cOut, cWrite, FLGS_IN, FLGS_WE, ISSUE, ISEL,
        input  ADAT, BDAT, FLGS, HAZARD, PEND, ERR
    );

    modport slave (
        input  aSel, bSel, cSel, cOut, cWrite, FLGS_IN, FLGS_WE, ISSUE, ISEL,
        output ADAT, BDAT, FLGS, HAZARD, PEND, ERR
    );
endinterface

// File: rtl/regfile_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// Simultaneous inc and dec cancel; ovf flags an inc lost at saturation.
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          ovf
);
    localparam logic [CW-1:0] MAX = '1;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    assign ovf = inc && !dec && (count == MAX);

    // Count issued-but-not-written-back results, clamped at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != MAX) begin
            count <= count + ONE;
        end else if (dec && !inc && count != '0) begin
            count <= count - ONE;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-bypassed operand reads, flags register and a
// per-register pending-write scoreboard driving HAZARD / PEND / ERR.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    regfile_sb_if.slave  bus
);
    word_t           regs [NREG];
    flags_t          flgs_q;
    logic            err_q;
    logic [CW-1:0]   cnt  [NREG];
    logic [NREG-1:0] ovf;
    logic [NREG-1:0] pend;

    for (genvar i = 0; i < NREG; i++) begin : g_sb
        sb_counter #(.CW(CW)) u_cnt (
            .clk   (CLK),
            .rst   (RST),
            .inc   (bus.ISSUE  && bus.ISEL == reg_sel_t'(i)),
            .dec   (bus.cWrite && bus.cSel == reg_sel_t'(i)),
            .count (cnt[i]),
            .ovf   (ovf[i])
        );
        assign pend[i] = (cnt[i] != '0);
    end

    // Writeback into the register array; every register, r0 included, is writable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.cWrite) begin
            regs[bus.cSel] <= bus.cOut;
        end
    end

    // Flags register loads from the ALU on FLGS_WE, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flgs_q <= '0;
        end else if (bus.FLGS_WE) begin
            flgs_q <= bus.FLGS_IN;
        end
    end

    // Sticky overflow: any issue lost to a saturated counter latches ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (|ovf) begin
            err_q <= 1'b1;
        end
    end

    // Same-cycle writeback is forwarded so a dependent read never sees stale data.
    assign bus.ADAT   = (bus.cWrite && bus.cSel == bus.aSel) ? bus.cOut : regs[bus.aSel];
    assign bus.BDAT   = (bus.cWrite && bus.cSel == bus.bSel) ? bus.cOut : regs[bus.bSel];
    // Hazard uses registered counts only, so it clears the cycle after the last writeback.
    assign bus.HAZARD = pend[bus.aSel] | pend[bus.bSel];
    assign bus.PEND   = pend;
    assign bus.FLGS   = flgs_q;
    assign bus.ERR    = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table followed by randomized traffic
// compared against a behavioural model of registers, flags and pending counts.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    int   passes = 0;
    int   total  = 0;

    regfile_sb_if bus();

    regfile_sb dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  csel;
        logic [15:0] cout;
        logic        cw;
        logic [7:0]  fin;
        logic        fwe;
        logic        issue;
        logic [2:0]  isel;
        logic        chk;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eh;
        logic [7:0]  ep;
        logic [7:0]  ef;
        logic        ee;
    } vec_t;

    vec_t vecs [22];

    // behavioural model state
    logic [15:0] m_reg [8];
    int          m_cnt [8];
    logic [7:0]  m_flg;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] cs, input logic [15:0] co, input logic cw,
                         input logic [7:0] fin, input logic fwe, input logic iss,
                         input logic [2:0] isel);
        rst         = r;
        bus.aSel    = a;
        bus.bSel    = b;
        bus.cSel    = cs;
        bus.cOut    = co;
        bus.cWrite  = cw;
        bus.FLGS_IN = fin;
        bus.FLGS_WE = fwe;
        bus.ISSUE   = iss;
        bus.ISEL    = isel;
    endtask

    // Model step: apply the architectural rules for one clock edge.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i] = '0;
                m_cnt[i] = 0;
            end
            m_flg = '0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                bit inc = bus.ISSUE && (int'(bus.ISEL) == i);
                bit dec = bus.cWrite && (int'(bus.cSel) == i);
                if (inc && !dec) begin
                    if (m_cnt[i] == 3) m_err = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else if (dec && !inc && m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (bus.cWrite) m_reg[bus.cSel] = bus.cOut;
            if (bus.FLGS_WE) m_flg = bus.FLGS_IN;
        end
    endtask

    task automatic model_check();
        logic [15:0] ea, eb;
        logic [7:0]  ep;
        ea = (bus.cWrite && bus.cSel == bus.aSel) ? bus.cOut : m_reg[bus.aSel];
        eb = (bus.cWrite && bus.cSel == bus.bSel) ? bus.cOut : m_reg[bus.bSel];
        for (int i = 0; i < 8; i++) ep[i] = (m_cnt[i] != 0);
        chk("rnd_adat",   32'(bus.ADAT),   32'(ea));
        chk("rnd_bdat",   32'(bus.BDAT),   32'(eb));
        chk("rnd_hazard", 32'(bus.HAZARD), 32'((m_cnt[bus.aSel] != 0) || (m_cnt[bus.bSel] != 0)));
        chk("rnd_pend",   32'(bus.PEND),   32'(ep));
        chk("rnd_flgs",   32'(bus.FLGS),   32'(m_flg));
        chk("rnd_err",    32'(bus.ERR),    32'(m_err));
    endtask

    initial begin
        // rst a b csel cout cw fin fwe issue isel | chk ea eb eh ep ef ee
        vecs[0]  = '{1,0,0,3,16'hBEEF,1,8'hFF,1,1,3, 0, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[1]  = '{0,3,3,0,16'h0,0,8'h00,0,0,0,    1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[2]  = '{0,0,1,5,16'h1234,1,8'h00,0,0,0, 1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[3]  = '{0,5,5,0,16'h0,0,8'h00,0,0,0,    1, 16'h1234,16'h1234,0,8'h00,8'h00,0};
        vecs[4]  = '{0,0,0,2,16'h0001,1,8'h00,0,0,0, 1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[5]  = '{0,2,5,2,16'hA5A5,1,8'h00,0,0,0, 1, 16'hA5A5,16'h1234,0,8'h00,8'h00,0};
        vecs[6]  = '{0,2,2,0,16'h0,0,8'h00,0,0,0,    1, 16'hA5A5,16'hA5A5,0,8'h00,8'h00,0};
        vecs[7]  = '{0,0,0,0,16'h0,0,8'h00,0,1,4,    1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[8]  = '{0,4,0,0,16'h0,0,8'h00,0,0,0,    1, 16'h0,16'h0,1,8'h10,8'h00,0};
        vecs[9]  = '{0,4,4,4,16'h4444,1,8'h00,0,0,0, 1, 16'h4444,16'h4444,1,8'h10,8'h00,0};
        vecs[10] = '{0,4,4,0,16'h0,0,8'h00,0,0,0,    1, 16'h4444,16'h4444,0,8'h00,8'h00,0};
        vecs[11] = '{0,0,0,0,16'h0,0,8'h00,0,1,1,    1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[12] = '{0,0,0,0,16'h0,0,8'h00,0,1,1,    1, 16'h0,16'h0,0,8'h02,8'h00,0};
        vecs[13] = '{0,0,0,0,16'h0,0,8'h00,0,1,1,    1, 16'h0,16'h0,0,8'h02,8'h00,0};
        vecs[14] = '{0,1,0,1,16'h0011,1,8'h00,0,1,1, 1, 16'h0011,16'h0,1,8'h02,8'h00,0};
        vecs[15] = '{0,1,0,0,16'h0,0,8'h00,0,1,1,    1, 16'h0011,16'h0,1,8'h02,8'h00,0};
        vecs[16] = '{0,0,0,0,16'h0,0,8'h81,1,0,0,    1, 16'h0,16'h0,0,8'h02,8'h00,1};
        vecs[17] = '{0,6,1,0,16'h0,0,8'h00,0,1,6,    1, 16'h0,16'h0011,1,8'h02,8'h81,1};
        vecs[18] = '{0,6,6,1,16'h0022,1,8'h00,0,0,0, 1, 16'h0,16'h0,1,8'h42,8'h81,1};
        vecs[19] = '{1,1,6,0,16'h0,0,8'h55,1,1,2,    1, 16'h0022,16'h0,1,8'h42,8'h81,1};
        vecs[20] = '{0,1,6,0,16'h0,0,8'h00,0,0,0,    1, 16'h0,16'h0,0,8'h00,8'h00,0};
        vecs[21] = '{0,2,5,0,16'h0,0,8'h00,0,0,0,    1, 16'h0,16'h0,0,8'h00,8'h00,0};

        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].a, vecs[k].b, vecs[k].csel, vecs[k].cout,
                  vecs[k].cw, vecs[k].fin, vecs[k].fwe, vecs[k].issue, vecs[k].isel);
            #1;
            if (vecs[k].chk) begin
                chk($sformatf("v%0d_adat", k),   32'(bus.ADAT),   32'(vecs[k].ea));
                chk($sformatf("v%0d_bdat", k),   32'(bus.BDAT),   32'(vecs[k].eb));
                chk($sformatf("v%0d_hazard", k), 32'(bus.HAZARD), 32'(vecs[k].eh));
                chk($sformatf("v%0d_pend", k),   32'(bus.PEND),   32'(vecs[k].ep));
                chk($sformatf("v%0d_flgs", k),   32'(bus.FLGS),   32'(vecs[k].ef));
                chk($sformatf("v%0d_err", k),    32'(bus.ERR),    32'(vecs[k].ee));
            end
        end

        // The table ends with the design in its reset state.
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_flg = '0;
        m_err = 1'b0;

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 59) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 1) == 1),
                  8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) < 2), 3'($urandom_range(0, 7)));
            #1;
            model_check();
            model_step();
        end

        @(negedge clk);
        drive(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
